// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO drain path.
package fifo_pkg;

    localparam int FIFO_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, WAIT, STREAM} reader_state_e;

    typedef logic [FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready output stream; master is the reader side.
interface fifo_stream_reader_if
    import fifo_pkg::*;
#(
    parameter int W = FIFO_WIDTH
) ();

    logic [W-1:0] fifo_data_out;
    logic         fifo_empty;
    logic         fifo_almostfull;
    logic         fifo_rd_en;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;

    modport master (
        input  fifo_data_out, fifo_empty, fifo_almostfull, m_ready,
        output fifo_rd_en, m_data, m_valid
    );

    modport slave (
        output fifo_data_out, fifo_empty, fifo_almostfull, m_ready,
        input  fifo_rd_en, m_data, m_valid
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer; ent0 is always the head.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int W = FIFO_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head
);

    logic [W-1:0] ent0, ent1;

    assign head = ent0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= push_data;
                    else             ent1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                // simultaneous push/pop: occupancy unchanged, new word goes behind the survivor
                2'b11: begin
                    if (occ == 2'd2) begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end else begin
                        ent0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Batching drain stage for the sync FIFO: waits for almostfull or an idle timeout,
// then streams words out through a skid buffer. FIFO_READER_STATS_EN adds word_cnt.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = fifo_pkg::FIFO_WIDTH,
    parameter int TIMEOUT    = 8,
    parameter int TMR_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo_stream_reader_if.master  bus,
    output logic                  busy
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]           word_cnt
`endif
);

    import fifo_pkg::*;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    reader_state_e    state;
    logic [TMR_W-1:0] timer;
    logic             rd_pend;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       inflight;

    assign bus.m_valid = (occ != 2'd0);
    assign pop         = bus.m_valid && bus.m_ready;
    // words held or arriving next cycle; a pop this cycle frees a slot for this cycle's read
    assign inflight    = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
    assign bus.fifo_rd_en = (state == STREAM) && !bus.fifo_empty && (inflight < 3'd2);
    assign busy        = (state != IDLE) || bus.m_valid || rd_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            timer   <= '0;
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= bus.fifo_rd_en;
            case (state)
                IDLE: begin
                    if (bus.fifo_almostfull) begin
                        state <= STREAM;
                    end else if (!bus.fifo_empty) begin
                        timer <= '0;
                        state <= (TIMEOUT == 0) ? STREAM : WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    if (bus.fifo_almostfull || timer == TMR_LAST) state <= STREAM;
                    else if (bus.fifo_empty)                     state <= IDLE;
                end
                STREAM: begin
                    if (bus.fifo_empty) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    fifo_skid_buf #(.W(FIFO_WIDTH)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend),
        .push_data (bus.fifo_data_out),
        .pop       (pop),
        .occ       (occ),
        .head      (bus.m_data)
    );

`ifdef FIFO_READER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   word_cnt <= '0;
        else if (pop) word_cnt <= word_cnt + 32'd1;
    end
`endif

endmodule
